// File: rtl/lector_destinos_pkg.sv
// Shared types for the destination drain: FSM state encoding, destination tags
// and the mapping from a granted destination to its pop state.
package lector_destinos_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP0 = 2'd1,
        ST_POP1 = 2'd2
    } state_t;

    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;

    function automatic state_t pop_state(input logic dest);
        return (dest == DEST_D1) ? ST_POP1 : ST_POP0;
    endfunction

endpackage

// File: rtl/lector_destinos_if.sv
// Bundle between the drain, the D0/D1 FIFOs and the consumer of the tagged stream.
// master = the drain itself, slave = FIFOs plus downstream/configuration side.
interface lector_destinos_if #(
    parameter int BITNUMBER = 8,
    parameter int CNT_WIDTH = 8
);
    logic                 enable;
    logic                 clear_cnt;
    logic                 D0_can_pop;
    logic                 D1_can_pop;
    logic [BITNUMBER-1:0] D0_data_out;
    logic [BITNUMBER-1:0] D1_data_out;
    logic                 pop_D0;
    logic                 pop_D1;
    logic [BITNUMBER-1:0] data_out;
    logic                 valid_out;
    logic                 dest_out;
    logic [CNT_WIDTH-1:0] cnt_D0;
    logic [CNT_WIDTH-1:0] cnt_D1;
    logic                 idle;

    modport master (
        input  enable, clear_cnt,
        input  D0_can_pop, D1_can_pop, D0_data_out, D1_data_out,
        output pop_D0, pop_D1,
        output data_out, valid_out, dest_out,
        output cnt_D0, cnt_D1, idle
    );

    modport slave (
        output enable, clear_cnt,
        output D0_can_pop, D1_can_pop, D0_data_out, D1_data_out,
        input  pop_D0, pop_D1,
        input  data_out, valid_out, dest_out,
        input  cnt_D0, cnt_D1, idle
    );

endinterface

// File: rtl/lector_destinos_contador_sat.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module contador_sat #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/lector_destinos.sv
// Drains FIFOs D0/D1 round-robin into one tagged word stream with a fixed
// two-cycle pop-to-output latency, and keeps saturating per-destination counts.
module lector_destinos
    import lector_destinos_pkg::*;
#(
    parameter int BITNUMBER = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    lector_destinos_if.master bus
);

    state_t               state;
    state_t               state_nxt;
    logic                 rr_last;
    logic                 rr_nxt;
    logic                 gnt;
    logic                 elig0;
    logic                 elig1;
    logic                 pop_d0_q;
    logic                 pop_d1_q;
    logic                 idle_q;
    logic                 s1_popped;
    logic                 s1_dest;
    logic                 valid_q;
    logic                 dest_q;
    logic [BITNUMBER-1:0] data_q;
    logic                 inc_d0;
    logic                 inc_d1;
    logic [CNT_WIDTH-1:0] cnt_d0;
    logic [CNT_WIDTH-1:0] cnt_d1;

    // can_pop is one cycle stale, so the FIFO popped this cycle sits out the next.
    assign elig0 = bus.enable && bus.D0_can_pop && (state != ST_POP0);
    assign elig1 = bus.enable && bus.D1_can_pop && (state != ST_POP1);

    always_comb begin
        state_nxt = ST_IDLE;
        rr_nxt    = rr_last;
        gnt       = DEST_D0;
        if (elig0 || elig1) begin
            if (elig0 && elig1) begin
                gnt = ~rr_last;
            end else begin
                gnt = elig1 ? DEST_D1 : DEST_D0;
            end
            state_nxt = pop_state(gnt);
            rr_nxt    = gnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            rr_last  <= DEST_D1;
            pop_d0_q <= 1'b0;
            pop_d1_q <= 1'b0;
            idle_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_last  <= rr_nxt;
            pop_d0_q <= (state_nxt == ST_POP0);
            pop_d1_q <= (state_nxt == ST_POP1);
            // Next-cycle view of: no pop, nothing in stage1, nothing on the output.
            idle_q   <= (state_nxt == ST_IDLE) && (state == ST_IDLE) && !s1_popped;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_popped <= 1'b0;
            s1_dest   <= DEST_D0;
            valid_q   <= 1'b0;
            dest_q    <= DEST_D0;
            data_q    <= '0;
        end else begin
            s1_popped <= (state != ST_IDLE);
            s1_dest   <= (state == ST_POP1) ? DEST_D1 : DEST_D0;
            valid_q   <= s1_popped;
            if (s1_popped) begin
                data_q <= (s1_dest == DEST_D1) ? bus.D1_data_out : bus.D0_data_out;
                dest_q <= s1_dest;
            end
        end
    end

    assign inc_d0 = valid_q && (dest_q == DEST_D0);
    assign inc_d1 = valid_q && (dest_q == DEST_D1);

    contador_sat #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_d0 (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_d0),
        .clr   (bus.clear_cnt),
        .cnt   (cnt_d0)
    );

    contador_sat #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_d1 (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_d1),
        .clr   (bus.clear_cnt),
        .cnt   (cnt_d1)
    );

    assign bus.pop_D0    = pop_d0_q;
    assign bus.pop_D1    = pop_d1_q;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.dest_out  = dest_q;
    assign bus.cnt_D0    = cnt_d0;
    assign bus.cnt_D1    = cnt_d1;
    assign bus.idle      = idle_q;

endmodule

// File: tb/tb_lector_destinos.sv
// Directed bench for lector_destinos: queue-backed D0/D1 FIFO models with a
// registered can_pop, one task per scenario, hand-computed expected streams.
module tb_lector_destinos;

    localparam int BW = 8;
    localparam int CW = 2;

    logic    clk;
    logic    reset;
    int      vectors     = 0;
    int      miscompares = 0;
    int      underflow   = 0;
    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];

    lector_destinos_if #(.BITNUMBER(BW), .CNT_WIDTH(CW)) bus ();

    lector_destinos #(.BITNUMBER(BW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO models: data valid the cycle after pop, can_pop registered from post-pop fill.
    always @(posedge clk) begin
        if (bus.pop_D0) begin
            if (q0.size() == 0) underflow <= underflow + 1;
            else bus.D0_data_out <= q0.pop_front();
        end
        bus.D0_can_pop <= (q0.size() != 0);
        if (bus.pop_D1) begin
            if (q1.size() == 0) underflow <= underflow + 1;
            else bus.D1_data_out <= q1.pop_front();
        end
        bus.D1_can_pop <= (q1.size() != 0);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic flush();
        bus.enable = 1'b0;
        repeat (3) tick();
        q0.delete();
        q1.delete();
        repeat (2) tick();
        bus.clear_cnt = 1'b1;
        tick();
        bus.clear_cnt = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [16:0] outs;
        logic [2:0]  got, exp;
        logic [8:0]  gw, ew;
        reset = 1'b0;
        bus.enable = 1'b1;
        q0 = '{8'h00, 8'h01, 8'h02, 8'h03};
        q1 = '{8'h80, 8'h81, 8'h82, 8'h83};
        for (int i = 0; i < 2; i++) begin
            tick();
            outs = {bus.pop_D0, bus.pop_D1, bus.valid_out, bus.dest_out, bus.idle,
                    bus.data_out, bus.cnt_D0, bus.cnt_D1};
            vectors++;
            if (outs !== 17'd0) begin
                miscompares++;
                $display("FAIL t1_in_reset cyc=%0d got outputs %h expected 0", i, outs);
            end
        end
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            exp = {(c % 2 == 0), (c % 2 == 1), (c >= 2)};
            got = {bus.pop_D0, bus.pop_D1, bus.valid_out};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL t1_stream c=%0d got pop0/pop1/valid=%b expected %b", c, got, exp);
            end
            if (exp[0]) begin
                ew = (c % 2 == 0) ? {1'b0, 8'h00 + 8'((c - 2) / 2)} : {1'b1, 8'h80 + 8'((c - 3) / 2)};
                gw = {bus.dest_out, bus.data_out};
                vectors++;
                if (gw !== ew) begin
                    miscompares++;
                    $display("FAIL t1_word c=%0d got dest/data=%h expected %h", c, gw, ew);
                end
            end
        end
        bus.enable = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({bus.cnt_D0, bus.cnt_D1} !== {2'd3, 2'd3}) begin
            miscompares++;
            $display("FAIL t1_counts got cnt_D0=%0d cnt_D1=%0d expected 3 3", bus.cnt_D0, bus.cnt_D1);
        end
        flush();
    endtask

    task automatic test_interleave();
        logic [2:0] got, exp;
        logic [8:0] gw, ew;
        logic [7:0] words [4];
        words = '{8'h10, 8'h20, 8'h11, 8'h21};
        q0 = '{8'h10, 8'h11};
        q1 = '{8'h20, 8'h21};
        repeat (2) tick();
        bus.enable = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            exp = {(c == 0 || c == 2), (c == 1 || c == 3), (c >= 2 && c <= 5)};
            got = {bus.pop_D0, bus.pop_D1, bus.valid_out};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL t3_stream c=%0d got pop0/pop1/valid=%b expected %b", c, got, exp);
            end
            if (exp[0]) begin
                ew = {1'((c - 2) % 2), words[c-2]};
                gw = {bus.dest_out, bus.data_out};
                vectors++;
                if (gw !== ew) begin
                    miscompares++;
                    $display("FAIL t3_word c=%0d got dest/data=%h expected %h", c, gw, ew);
                end
            end
        end
        vectors++;
        if ({bus.cnt_D0, bus.cnt_D1, bus.idle} !== {2'd2, 2'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL t3_end got cnt_D0=%0d cnt_D1=%0d idle=%b expected 2 2 1",
                     bus.cnt_D0, bus.cnt_D1, bus.idle);
        end
        flush();
    endtask

    task automatic test_d0_only();
        logic [2:0] got, exp;
        logic [8:0] gw, ew;
        q0 = '{8'hA1, 8'hA2, 8'hA3};
        repeat (2) tick();
        bus.enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            exp = {(c == 0 || c == 2 || c == 4), 1'b0, (c == 2 || c == 4 || c == 6)};
            got = {bus.pop_D0, bus.pop_D1, bus.valid_out};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL t2_stream c=%0d got pop0/pop1/valid=%b expected %b", c, got, exp);
            end
            if (exp[0]) begin
                ew = {1'b0, 8'hA1 + 8'((c - 2) / 2)};
                gw = {bus.dest_out, bus.data_out};
                vectors++;
                if (gw !== ew) begin
                    miscompares++;
                    $display("FAIL t2_word c=%0d got dest/data=%h expected %h", c, gw, ew);
                end
            end
        end
        vectors++;
        if ({underflow, bus.cnt_D0, bus.idle} !== {32'd0, 2'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL t2_end got underflow=%0d cnt_D0=%0d idle=%b expected 0 3 1",
                     underflow, bus.cnt_D0, bus.idle);
        end
        flush();
    endtask

    task automatic test_enable_drop();
        logic [2:0] got, exp;
        logic [8:0] gw, ew;
        q0 = '{8'h30, 8'h31, 8'h32};
        q1 = '{8'h40, 8'h41, 8'h42};
        repeat (2) tick();
        bus.enable = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            exp = {(c == 6), (c == 0), (c == 2 || c == 8)};
            got = {bus.pop_D0, bus.pop_D1, bus.valid_out};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL t4_stream c=%0d got pop0/pop1/valid=%b expected %b", c, got, exp);
            end
            if (exp[0]) begin
                ew = (c == 2) ? {1'b1, 8'h40} : {1'b0, 8'h30};
                gw = {bus.dest_out, bus.data_out};
                vectors++;
                if (gw !== ew) begin
                    miscompares++;
                    $display("FAIL t4_word c=%0d got dest/data=%h expected %h", c, gw, ew);
                end
            end
            if (c == 4) begin
                vectors++;
                if (bus.idle !== 1'b1) begin
                    miscompares++;
                    $display("FAIL t4_idle_gap got idle=%b expected 1", bus.idle);
                end
            end
            if (c == 0 || c == 6) bus.enable = 1'b0;
            if (c == 5) bus.enable = 1'b1;
        end
        flush();
    endtask

    task automatic test_saturate();
        logic [2:0] got, exp;
        logic [8:0] gw, ew;
        q1 = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        repeat (2) tick();
        bus.enable = 1'b1;
        for (int c = 0; c < 14; c++) begin
            tick();
            exp = {1'b0, (c % 2 == 0 && c <= 10), (c % 2 == 0 && c >= 2 && c <= 12)};
            got = {bus.pop_D0, bus.pop_D1, bus.valid_out};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL t5_stream c=%0d got pop0/pop1/valid=%b expected %b", c, got, exp);
            end
            if (exp[0]) begin
                ew = {1'b1, 8'h50 + 8'((c - 2) / 2)};
                gw = {bus.dest_out, bus.data_out};
                vectors++;
                if (gw !== ew) begin
                    miscompares++;
                    $display("FAIL t5_word c=%0d got dest/data=%h expected %h", c, gw, ew);
                end
            end
            if (c == 5 || c == 9 || c == 11 || c == 13) begin
                vectors++;
                if (bus.cnt_D1 !== ((c == 5) ? 2'd2 : (c == 13) ? 2'd0 : 2'd3)) begin
                    miscompares++;
                    $display("FAIL t5_cnt_D1 c=%0d got %0d expected %0d", c, bus.cnt_D1,
                             (c == 5) ? 2 : (c == 13) ? 0 : 3);
                end
            end
            bus.clear_cnt = (c == 12);
        end
        vectors++;
        if (bus.cnt_D0 !== 2'd0) begin
            miscompares++;
            $display("FAIL t5_cnt_D0 got %0d expected 0", bus.cnt_D0);
        end
        flush();
    endtask

    task automatic test_reset_midflight();
        logic [2:0]  got, exp;
        logic [8:0]  gw, ew;
        logic [12:0] outs;
        q0 = '{8'h60, 8'h61};
        repeat (2) tick();
        bus.enable = 1'b1;
        tick();
        vectors++;
        if ({bus.pop_D0, bus.pop_D1} !== 2'b10) begin
            miscompares++;
            $display("FAIL t6_first_pop got pop0/pop1=%b expected 10", {bus.pop_D0, bus.pop_D1});
        end
        q1.push_back(8'h70);
        tick();
        reset = 1'b0;
        #1;
        outs = {bus.pop_D0, bus.pop_D1, bus.valid_out, bus.idle, bus.dest_out, bus.data_out};
        vectors++;
        if (outs !== 13'd0) begin
            miscompares++;
            $display("FAIL t6_async_clear got outputs %h expected 0", outs);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (bus.valid_out !== 1'b0) begin
                miscompares++;
                $display("FAIL t6_in_reset cyc=%0d got valid=%b expected 0", i, bus.valid_out);
            end
        end
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            exp = {(c == 0), (c == 1), (c >= 2)};
            got = {bus.pop_D0, bus.pop_D1, bus.valid_out};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL t6_stream c=%0d got pop0/pop1/valid=%b expected %b", c, got, exp);
            end
            if (exp[0]) begin
                ew = (c == 2) ? {1'b0, 8'h61} : {1'b1, 8'h70};
                gw = {bus.dest_out, bus.data_out};
                vectors++;
                if (gw !== ew) begin
                    miscompares++;
                    $display("FAIL t6_word c=%0d got dest/data=%h expected %h", c, gw, ew);
                end
            end
        end
        flush();
    endtask

    initial begin
        reset         = 1'b0;
        bus.enable    = 1'b0;
        bus.clear_cnt = 1'b0;
        test_reset();
        test_interleave();
        test_d0_only();
        test_enable_drop();
        test_saturate();
        test_reset_midflight();
        vectors++;
        if (underflow !== 0) begin
            miscompares++;
            $display("FAIL fifo_underflow got %0d expected 0", underflow);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
